// File: rtl/framer_pkg.sv
// rtl/framer_pkg.sv - shared types and constants for the decision framer
// DECISION_FRAMER_CHECKSUM_EN adds the trailing CHK byte (7-byte frames instead of 6)
package framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_TYPE,
    ST_D3,
    ST_D2,
    ST_D1,
    ST_D0,
    ST_CHK
  } frame_state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

`ifdef DECISION_FRAMER_CHECKSUM_EN
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 6;
`endif

  typedef struct packed {
    logic [7:0]  dtype;
    logic [31:0] data;
  } decision_entry_t;

  function automatic logic [7:0] entry_chk(input decision_entry_t e);
    return e.dtype ^ e.data[31:24] ^ e.data[23:16] ^ e.data[15:8] ^ e.data[7:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, full/empty derived from the occupancy count
module sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers are exactly AW bits so they wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/decision_framer.sv
// rtl/decision_framer.sv - buffers decisions and serializes each into a UART byte frame
// DECISION_FRAMER_CHECKSUM_EN selects the 7-byte frame with trailing CHK
module decision_framer
  import framer_pkg::*;
#(
  parameter int         DEPTH    = 8,
  parameter logic [7:0] SOF_BYTE = SOF_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_type,
  input  logic [31:0]              in_data,
  output logic [7:0]               out_byte,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              drop_count,
  output logic [15:0]              frames_sent
);
  // Last byte state of a frame: D0 (6) or CHK (7) follows the frame length.
  localparam frame_state_t LAST_ST = frame_state_t'(3'(FRAME_LEN));

  frame_state_t    state;
  frame_state_t    state_nxt;
  decision_entry_t hold;
  decision_entry_t head;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            hs;
  logic            frame_done;

  assign in_ready   = !full;
  assign push       = in_valid && in_ready;
  assign out_valid  = (state != ST_IDLE);
  assign hs         = out_valid && out_ready;
  assign frame_done = hs && (state == LAST_ST);
  assign pop        = !empty && ((state == ST_IDLE) || frame_done);

  sync_fifo #(
    .WIDTH (40),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({in_type, in_data}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    if (state == ST_IDLE) begin
      if (!empty) state_nxt = ST_SOF;
    end else if (frame_done) begin
      state_nxt = empty ? ST_IDLE : ST_SOF;
    end else if (hs) begin
      state_nxt = frame_state_t'(state + 3'd1);
    end
  end

  // Byte comes only from state and the holding register, so it is stable under stall.
  always_comb begin
    out_byte = '0;
    case (state)
      ST_SOF:  out_byte = SOF_BYTE;
      ST_TYPE: out_byte = hold.dtype;
      ST_D3:   out_byte = hold.data[31:24];
      ST_D2:   out_byte = hold.data[23:16];
      ST_D1:   out_byte = hold.data[15:8];
      ST_D0:   out_byte = hold.data[7:0];
      ST_CHK:  out_byte = entry_chk(hold);
      default: out_byte = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      hold        <= '0;
      frames_sent <= '0;
      drop_count  <= '0;
    end else begin
      state <= state_nxt;
      if (pop)        hold        <= head;
      if (frame_done) frames_sent <= frames_sent + 16'd1;
      if (in_valid && !in_ready && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_decision_framer.sv
// tb/tb_decision_framer.sv - self-checking bench for decision_framer
module tb_decision_framer;
  localparam int DEPTH = 8;
`ifdef DECISION_FRAMER_CHECKSUM_EN
  localparam int FL = 7;
`else
  localparam int FL = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_type = '0;
  logic [31:0] in_data = '0;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  fifo_count;
  logic [15:0] drop_count;
  logic [15:0] frames_sent;

  decision_framer #(
    .DEPTH    (DEPTH),
    .SOF_BYTE (8'hA5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_type     (in_type),
    .in_data     (in_data),
    .out_byte    (out_byte),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fifo_count  (fifo_count),
    .drop_count  (drop_count),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         frames_exp = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0]  t;
    logic [31:0] d;
    int          per;
    logic [7:0]  chk;
  } vec_t;
  vec_t vec[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bx(input logic [7:0] t, input logic [31:0] d);
    return t ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

  task automatic expect_frame(input logic [7:0] t, input logic [31:0] d, input logic [7:0] chk);
    exp_q.push_back(8'hA5);
    exp_q.push_back(t);
    exp_q.push_back(d[31:24]);
    exp_q.push_back(d[23:16]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    if (FL == 7) exp_q.push_back(chk);
    frames_exp++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] t, input logic [31:0] d, input logic [7:0] chk);
    in_valid = 1'b1;
    in_type  = t;
    in_data  = d;
    if (in_ready) expect_frame(t, d, chk);
    cyc();
  endtask

  // Scoreboard: every output handshake pops one expected byte; stalls must hold the byte.
  logic       stalled = 1'b0;
  logic [7:0] stall_byte = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled <= 1'b0;
    end else begin
      if (stalled && out_valid) check("stall_hold", out_byte, stall_byte);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected no byte", out_byte);
        end else begin
          check("frame_byte", out_byte, exp_q.pop_front());
        end
      end
      stalled    <= out_valid && !out_ready;
      stall_byte <= out_byte;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n;

  initial begin
    vec[0] = '{8'h42, 32'h11223344, 1, 8'h06};
    vec[1] = '{8'h42, 32'h11223344, 3, 8'h06};
    vec[2] = '{8'h00, 32'h00000000, 1, 8'h00};
    vec[3] = '{8'hFF, 32'hFFFFFFFF, 2, 8'hFF};
    vec[4] = '{8'h01, 32'h80402010, 1, 8'hF1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_byte", out_byte, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_frames_sent", frames_sent, 0);
    rst_n = 1'b1;
    cyc();

    // Single frames, with and without backpressure.
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b0;
      push_word(vec[i].t, vec[i].d, vec[i].chk);
      in_valid = 1'b0;
      check("pre_pop_count", fifo_count, 1);
      check("pre_pop_valid", out_valid, 0);
      cyc();
      check("sof_valid", out_valid, 1);
      check("sof_byte", out_byte, 8'hA5);
      n = 0;
      while (out_valid && n < 200) begin
        out_ready = ((n % vec[i].per) == vec[i].per - 1);
        cyc();
        n++;
      end
      out_ready = 1'b0;
      check("frame_cycles", n, FL * vec[i].per);
      check("frames_sent", frames_sent, frames_exp);
      check("queue_drained", exp_q.size(), 0);
    end

    // Back-to-back: SOF of frame 1 is already consumed when the third push completes.
    out_ready = 1'b1;
    push_word(8'h10, 32'hDEADBEEF, bx(8'h10, 32'hDEADBEEF));
    push_word(8'h20, 32'hCAFEF00D, bx(8'h20, 32'hCAFEF00D));
    push_word(8'h30, 32'h01020304, bx(8'h30, 32'h01020304));
    in_valid = 1'b0;
    n = 0;
    while (out_valid && n < 100) begin
      cyc();
      n++;
    end
    check("b2b_contiguous", n, 3 * FL - 1);
    check("b2b_frames_sent", frames_sent, frames_exp);
    check("b2b_drained", exp_q.size(), 0);

    // Overflow: one word sits in the holding register, DEPTH more fill the FIFO.
    out_ready = 1'b0;
    n = 0;
    while (in_ready && n < 20) begin
      push_word(8'h50 + 8'(n), 32'h1000_0000 + n, bx(8'h50 + 8'(n), 32'h1000_0000 + n));
      n++;
    end
    in_valid = 1'b0;
    check("ovf_accepted", n, DEPTH + 1);
    check("ovf_fifo_count", fifo_count, DEPTH);
    check("ovf_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_type  = 8'hEE;
    in_data  = 32'hBADBAD00;
    repeat (3) cyc();
    in_valid = 1'b0;
    check("ovf_drop_count", drop_count, 3);
    check("ovf_fifo_still_full", fifo_count, DEPTH);
    cyc();
    check("ovf_drop_hold", drop_count, 3);
    out_ready = 1'b1;
    n = 0;
    while ((out_valid || fifo_count != 0) && n < 500) begin
      cyc();
      n++;
    end
    check("ovf_frames_sent", frames_sent, frames_exp);
    check("ovf_drained", exp_q.size(), 0);

    // Reset mid-frame after the D3 handshake with two words queued.
    out_ready = 1'b0;
    push_word(8'h61, 32'hA1A2A3A4, bx(8'h61, 32'hA1A2A3A4));
    push_word(8'h62, 32'hB1B2B3B4, bx(8'h62, 32'hB1B2B3B4));
    push_word(8'h63, 32'hC1C2C3C4, bx(8'h63, 32'hC1C2C3C4));
    in_valid = 1'b0;
    check("mid_fifo_count", fifo_count, 2);
    out_ready = 1'b1;
    repeat (3) cyc();
    out_ready = 1'b0;
    check("mid_d2_byte", out_byte, 8'hA2);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    frames_exp = 0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_fifo_count", fifo_count, 0);
    check("mid_rst_frames_sent", frames_sent, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    out_ready = 1'b1;
    push_word(8'h77, 32'h55667788, bx(8'h77, 32'h55667788));
    in_valid = 1'b0;
    cyc();
    check("post_rst_sof_valid", out_valid, 1);
    check("post_rst_sof_byte", out_byte, 8'hA5);
    n = 0;
    while (out_valid && n < 100) begin
      cyc();
      n++;
    end
    check("post_rst_frames_sent", frames_sent, 1);
    check("post_rst_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
